// File: rtl/mem_scheduler.sv
// Three-requester round-robin scheduler onto a single shared memory bus.
// One transaction at a time: IDLE arbitrates, BUSY passes the owner through until ready, timeout or abort.
module mem_scheduler #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address_in,
  input  logic        m0_read_in,
  input  logic        m0_write_in,
  input  logic [3:0]  m0_write_mask_in,
  input  logic [31:0] m0_write_value_in,
  output logic [31:0] m0_read_value_out,
  output logic        m0_ready_out,
  output logic        m0_fault_out,
  input  logic [31:0] m1_address_in,
  input  logic        m1_read_in,
  input  logic        m1_write_in,
  input  logic [3:0]  m1_write_mask_in,
  input  logic [31:0] m1_write_value_in,
  output logic [31:0] m1_read_value_out,
  output logic        m1_ready_out,
  output logic        m1_fault_out,
  input  logic [31:0] m2_address_in,
  input  logic        m2_read_in,
  input  logic        m2_write_in,
  input  logic [3:0]  m2_write_mask_in,
  input  logic [31:0] m2_write_value_in,
  output logic [31:0] m2_read_value_out,
  output logic        m2_ready_out,
  output logic        m2_fault_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  input  logic        fault_in,
  output logic [1:0]  grant_out,
  output logic        busy_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  NO_GRANT  = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] wait_q, wait_d;

  // Entry 3 is a permanently idle slot so a grant index can never select out of range.
  logic [31:0] addr_a  [0:3];
  logic [3:0]  mask_a  [0:3];
  logic [31:0] wval_a  [0:3];
  logic [3:0]  rd_a, wr_a, act;

  logic [31:0] rval_a  [0:2];
  logic [2:0]  rdy_a, flt_a;
  logic        g_act, timeout_hit;

  assign addr_a[0] = m0_address_in;
  assign addr_a[1] = m1_address_in;
  assign addr_a[2] = m2_address_in;
  assign addr_a[3] = '0;
  assign mask_a[0] = m0_write_mask_in;
  assign mask_a[1] = m1_write_mask_in;
  assign mask_a[2] = m2_write_mask_in;
  assign mask_a[3] = '0;
  assign wval_a[0] = m0_write_value_in;
  assign wval_a[1] = m1_write_value_in;
  assign wval_a[2] = m2_write_value_in;
  assign wval_a[3] = '0;
  assign rd_a = {1'b0, m2_read_in,  m1_read_in,  m0_read_in};
  assign wr_a = {1'b0, m2_write_in, m1_write_in, m0_write_in};
  assign act  = rd_a | wr_a;

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] idx;
    logic       found;
    rr_pick = NO_GRANT;
    found   = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      idx = 2'((int'(last) + i) % 3);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign g_act       = (state_q == BUSY) && act[grant_q];
  assign timeout_hit = g_act && !ready_in && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (|act[2:0]) begin
          state_d = BUSY;
          grant_d = rr_pick(last_q, act);
          wait_d  = '0;
        end
      end
      BUSY: begin
        // Abort, completion and timeout all release the bus and advance the rotation.
        if (!g_act || ready_in || timeout_hit) begin
          state_d = IDLE;
          grant_d = NO_GRANT;
          last_d  = grant_q;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    address_out     = '0;
    read_out        = 1'b0;
    write_out       = 1'b0;
    write_mask_out  = '0;
    write_value_out = '0;
    grant_out       = NO_GRANT;
    busy_out        = 1'b0;
    rdy_a           = '0;
    flt_a           = '0;
    for (int n = 0; n < 3; n++) rval_a[n] = '0;
    if (state_q == BUSY) begin
      address_out     = addr_a[grant_q];
      read_out        = rd_a[grant_q];
      write_out       = wr_a[grant_q];
      write_mask_out  = mask_a[grant_q];
      write_value_out = wval_a[grant_q];
      grant_out       = grant_q;
      busy_out        = 1'b1;
      for (int n = 0; n < 3; n++) begin
        if (g_act && grant_q == 2'(n)) begin
          if (ready_in) begin
            rval_a[n] = read_value_in;
            rdy_a[n]  = 1'b1;
            flt_a[n]  = fault_in;
          end else if (timeout_hit) begin
            rdy_a[n]  = 1'b1;
            flt_a[n]  = 1'b1;
          end
        end
      end
    end
  end

  assign m0_read_value_out = rval_a[0];
  assign m1_read_value_out = rval_a[1];
  assign m2_read_value_out = rval_a[2];
  assign {m2_ready_out, m1_ready_out, m0_ready_out} = rdy_a;
  assign {m2_fault_out, m1_fault_out, m0_fault_out} = flt_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= NO_GRANT;
      last_q  <= 2'd2;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed-vector bench for mem_scheduler (TIMEOUT=4) with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address_in, m1_address_in, m2_address_in;
  logic        m0_read_in, m1_read_in, m2_read_in;
  logic        m0_write_in, m1_write_in, m2_write_in;
  logic [3:0]  m0_write_mask_in, m1_write_mask_in, m2_write_mask_in;
  logic [31:0] m0_write_value_in, m1_write_value_in, m2_write_value_in;
  logic [31:0] m0_read_value_out, m1_read_value_out, m2_read_value_out;
  logic        m0_ready_out, m1_ready_out, m2_ready_out;
  logic        m0_fault_out, m1_fault_out, m2_fault_out;
  logic [31:0] address_out;
  logic        read_out, write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in, fault_in;
  logic [1:0]  grant_out;
  logic        busy_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_scheduler #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address_in(m0_address_in), .m0_read_in(m0_read_in), .m0_write_in(m0_write_in),
    .m0_write_mask_in(m0_write_mask_in), .m0_write_value_in(m0_write_value_in),
    .m0_read_value_out(m0_read_value_out), .m0_ready_out(m0_ready_out), .m0_fault_out(m0_fault_out),
    .m1_address_in(m1_address_in), .m1_read_in(m1_read_in), .m1_write_in(m1_write_in),
    .m1_write_mask_in(m1_write_mask_in), .m1_write_value_in(m1_write_value_in),
    .m1_read_value_out(m1_read_value_out), .m1_ready_out(m1_ready_out), .m1_fault_out(m1_fault_out),
    .m2_address_in(m2_address_in), .m2_read_in(m2_read_in), .m2_write_in(m2_write_in),
    .m2_write_mask_in(m2_write_mask_in), .m2_write_value_in(m2_write_value_in),
    .m2_read_value_out(m2_read_value_out), .m2_ready_out(m2_ready_out), .m2_fault_out(m2_fault_out),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in),
    .grant_out(grant_out), .busy_out(busy_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    {m0_read_in, m0_write_in, m1_read_in, m1_write_in, m2_read_in, m2_write_in} = '0;
  endtask

  initial begin
    reset = 1'b0;
    clear_reqs();
    m0_address_in = 32'h0; m1_address_in = 32'h0; m2_address_in = 32'h0;
    m0_write_mask_in = 4'h0; m1_write_mask_in = 4'h0; m2_write_mask_in = 4'h0;
    m0_write_value_in = 32'h0; m1_write_value_in = 32'h0; m2_write_value_in = 32'h0;
    read_value_in = 32'h0; ready_in = 1'b0; fault_in = 1'b0;
    #1;
    chk("rst_grant", 32'(grant_out), 32'd3);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_addr", address_out, 32'h0);
    step();
    reset = 1'b1;

    // Single read with immediate ready
    m0_address_in = 32'h0000_0010; m0_read_in = 1'b1;
    read_value_in = 32'hDEAD_BEEF; ready_in = 1'b1;
    #1;
    chk("rd_idle_grant", 32'(grant_out), 32'd3);
    chk("rd_idle_rdy", 32'(m0_ready_out), 32'd0);
    chk("rd_idle_readout", 32'(read_out), 32'd0);
    step();
    chk("rd_grant", 32'(grant_out), 32'd0);
    chk("rd_busy", 32'(busy_out), 32'd1);
    chk("rd_addr", address_out, 32'h0000_0010);
    chk("rd_readout", 32'(read_out), 32'd1);
    chk("rd_m0_rdy", 32'(m0_ready_out), 32'd1);
    chk("rd_m0_val", m0_read_value_out, 32'hDEAD_BEEF);
    chk("rd_m1_rdy", 32'(m1_ready_out), 32'd0);
    chk("rd_m1_val", m1_read_value_out, 32'h0);
    m0_read_in = 1'b0;
    step();
    chk("rd_after_grant", 32'(grant_out), 32'd3);

    // Fresh reset so rotation restarts at m0, then all three request continuously
    reset = 1'b0; #2; reset = 1'b1;
    m0_read_in = 1'b1; m1_read_in = 1'b1; m2_read_in = 1'b1;
    m0_address_in = 32'hA0; m1_address_in = 32'hA1; m2_address_in = 32'hA2;
    ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_idle%0d", k), 32'(grant_out), 32'd3);
      step();
      chk($sformatf("rr_grant%0d", k), 32'(grant_out), 32'(k % 3));
      chk($sformatf("rr_addr%0d", k), address_out, 32'hA0 + 32'(k % 3));
      chk($sformatf("rr_rdy%0d", k),
          32'({m2_ready_out, m1_ready_out, m0_ready_out}), 32'(1 << (k % 3)));
      step();
    end
    clear_reqs();

    // Write with fault returned alongside ready (last owner m2, so m0 wins)
    m0_write_in = 1'b1; m0_write_mask_in = 4'b0101; m0_write_value_in = 32'h1234_5678;
    m0_address_in = 32'h40; fault_in = 1'b1; ready_in = 1'b1;
    step();
    chk("wr_grant", 32'(grant_out), 32'd0);
    chk("wr_writeout", 32'(write_out), 32'd1);
    chk("wr_readout", 32'(read_out), 32'd0);
    chk("wr_mask", 32'(write_mask_out), 32'h5);
    chk("wr_value", write_value_out, 32'h1234_5678);
    chk("wr_m0_fault", 32'(m0_fault_out), 32'd1);
    chk("wr_m0_rdy", 32'(m0_ready_out), 32'd1);
    clear_reqs(); fault_in = 1'b0;
    step();
    chk("wr_after_grant", 32'(grant_out), 32'd3);

    // Timeout: m1 with read and write both set, memory never ready
    m1_read_in = 1'b1; m1_write_in = 1'b1; m1_address_in = 32'h80;
    ready_in = 1'b0; read_value_in = 32'h5555_AAAA;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("to_grant_c%0d", c), 32'(grant_out), 32'd1);
      chk($sformatf("to_rdy_c%0d", c), 32'(m1_ready_out), 32'd0);
    end
    chk("to_both_rd", 32'(read_out), 32'd1);
    chk("to_both_wr", 32'(write_out), 32'd1);
    step();
    chk("to_rdy_c4", 32'(m1_ready_out), 32'd1);
    chk("to_fault_c4", 32'(m1_fault_out), 32'd1);
    chk("to_val_c4", m1_read_value_out, 32'h0);
    clear_reqs();
    step();
    chk("to_after_grant", 32'(grant_out), 32'd3);
    chk("to_after_busy", 32'(busy_out), 32'd0);

    // Abort: m2 owns the bus (last owner m1), drops after 2 BUSY cycles while m0 waits
    m2_read_in = 1'b1; m0_read_in = 1'b1; m0_address_in = 32'hC0;
    step();
    chk("ab_grant_c1", 32'(grant_out), 32'd2);
    step();
    chk("ab_grant_c2", 32'(grant_out), 32'd2);
    m2_read_in = 1'b0;
    #1;
    chk("ab_m2_rdy", 32'(m2_ready_out), 32'd0);
    step();
    chk("ab_idle_grant", 32'(grant_out), 32'd3);
    step();
    chk("ab_next_grant", 32'(grant_out), 32'd0);
    ready_in = 1'b1;
    #1;
    chk("ab_m0_rdy", 32'(m0_ready_out), 32'd1);
    clear_reqs();
    step();
    ready_in = 1'b0;

    // Reset mid-transaction while m1 owns the bus
    m1_read_in = 1'b1; m1_address_in = 32'hE1;
    step();
    chk("rs_grant_m1", 32'(grant_out), 32'd1);
    reset = 1'b0;
    m0_read_in = 1'b1;
    #1;
    chk("rs_grant", 32'(grant_out), 32'd3);
    chk("rs_busy", 32'(busy_out), 32'd0);
    chk("rs_readout", 32'(read_out), 32'd0);
    chk("rs_addr", address_out, 32'h0);
    chk("rs_m1_rdy", 32'(m1_ready_out), 32'd0);
    step();
    chk("rs_held_grant", 32'(grant_out), 32'd3);
    reset = 1'b1;
    step();
    chk("rs_first_grant", 32'(grant_out), 32'd0);
    clear_reqs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
